// File: rtl/div_mm_sequencer.sv
// div_mm_sequencer
// Avalon-MM master that runs one full divide on the memory-mapped divider
// for each operand pair taken from a valid/ready stream. It returns the
// quotient and remainder on a valid/ready output stream.
// Sequence: clear done, write dividend, write divisor, start,
// wait for irq, read quotient, read remainder, present result.
// Optional feature macro: DIV_ZERO_BYPASS_EN. When it is defined, a zero
// divisor skips the bus entirely and returns an error result at once.
module div_mm_sequencer #(
    parameter int W       = 32,
    parameter int TMO_CYC = 255,
    parameter int TMO_W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dvnd,
    input  logic [W-1:0] in_dvsr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_quo,
    output logic [W-1:0] out_rmd,
    output logic         out_err,
    output logic [2:0]   m_address,
    output logic         m_chipselect,
    output logic         m_write,
    output logic [W-1:0] m_writedata,
    input  logic [W-1:0] m_readdata,
    input  logic         m_irq,
    output logic         busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_WDVND,
        S_WDVSR,
        S_START,
        S_WAIT,
        S_RQUO,
        S_RRMD,
        S_OUT
    } state_t;

    // Last counter value allowed in WAIT before the operation is abandoned.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [W-1:0]     dvnd_reg;
    logic [W-1:0]     dvsr_reg;
    logic [W-1:0]     quo_reg;
    logic [W-1:0]     rmd_reg;
    logic             err_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic             accept;
    logic             tmo_hit;

    assign accept  = in_valid && (state_reg == S_IDLE);
    // irq wins over a timeout that lands on the same cycle.
    assign tmo_hit = (state_reg == S_WAIT) && !m_irq && (tmo_reg == TMO_LAST);

    assign out_quo = quo_reg;
    assign out_rmd = rmd_reg;
    assign out_err = err_reg;

    // State register plus operand, result and timeout registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            dvnd_reg  <= '0;
            dvsr_reg  <= '0;
            quo_reg   <= '0;
            rmd_reg   <= '0;
            err_reg   <= 1'b0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        dvnd_reg <= in_dvnd;
                        dvsr_reg <= in_dvsr;
                        err_reg  <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
                        if (in_dvsr == '0) begin
                            quo_reg <= '1;
                            rmd_reg <= in_dvnd;
                            err_reg <= 1'b1;
                        end
`endif
                    end
                end
                S_START: tmo_reg <= '0;
                S_WAIT: begin
                    tmo_reg <= tmo_reg + TMO_W'(1);
                    if (tmo_hit) begin
                        quo_reg <= '0;
                        rmd_reg <= '0;
                        err_reg <= 1'b1;
                    end
                end
                S_RQUO: quo_reg <= m_readdata;
                S_RRMD: rmd_reg <= m_readdata;
                default: ;
            endcase
        end
    end

    // Next-state decode and bus/stream outputs, all decoded from the current state.
    always_comb begin
        state_next   = state_reg;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_address    = 3'd0;
        m_writedata  = '0;
        busy         = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef DIV_ZERO_BYPASS_EN
                    state_next = (in_dvsr == '0) ? S_OUT : S_CLR;
`else
                    state_next = S_CLR;
`endif
                end
            end
            S_CLR: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd6;
                state_next   = S_WDVND;
            end
            S_WDVND: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd0;
                m_writedata  = dvnd_reg;
                state_next   = S_WDVSR;
            end
            S_WDVSR: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd1;
                m_writedata  = dvsr_reg;
                state_next   = S_START;
            end
            S_START: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = 3'd2;
                state_next   = S_WAIT;
            end
            S_WAIT: begin
                m_address = 3'd5;
                if (m_irq) begin
                    state_next = S_RQUO;
                end else if (tmo_hit) begin
                    state_next = S_OUT;
                end
            end
            S_RQUO: begin
                m_chipselect = 1'b1;
                m_address    = 3'd3;
                state_next   = S_RRMD;
            end
            S_RRMD: begin
                m_chipselect = 1'b1;
                m_address    = 3'd4;
                state_next   = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_div_mm_sequencer.sv
// Testbench for div_mm_sequencer. It includes a small behavioural model of
// the divider slave (registers, start-to-irq delay, combinational read data)
// and a bus monitor that records every chip-selected cycle.
module tb_div_mm_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_dvnd;
    logic [W-1:0] in_dvsr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quo;
    logic [W-1:0] out_rmd;
    logic         out_err;
    logic [2:0]   m_address;
    logic         m_chipselect;
    logic         m_write;
    logic [W-1:0] m_writedata;
    logic [W-1:0] m_readdata;
    logic         m_irq;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_mm_sequencer #(.W(W), .TMO_CYC(255), .TMO_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dvnd(in_dvnd), .in_dvsr(in_dvsr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quo(out_quo), .out_rmd(out_rmd), .out_err(out_err),
        .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write(m_write), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_irq(m_irq), .busy(busy)
    );

    // Divider slave model: irq_delay = 0 means the divider never finishes.
    int           irq_delay = 34;
    int           d_cnt;
    logic [W-1:0] d_dvnd, d_dvsr, d_quo, d_rmd;
    logic         d_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            d_dvnd <= '0; d_dvsr <= '0; d_quo <= '0; d_rmd <= '0;
            d_done <= 1'b0; d_cnt <= 0;
        end else begin
            if (d_cnt > 0) begin
                d_cnt <= d_cnt - 1;
                if (d_cnt == 1) d_done <= 1'b1;
            end
            if (m_chipselect && m_write) begin
                case (m_address)
                    3'd0: d_dvnd <= m_writedata;
                    3'd1: d_dvsr <= m_writedata;
                    3'd2: begin
                        d_cnt <= irq_delay;
                        d_quo <= (d_dvsr == 0) ? '1 : d_dvnd / d_dvsr;
                        d_rmd <= (d_dvsr == 0) ? d_dvnd : d_dvnd % d_dvsr;
                    end
                    3'd6: d_done <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign m_irq = d_done;

    always_comb begin
        m_readdata = '0;
        case (m_address)
            3'd3: m_readdata = d_quo;
            3'd4: m_readdata = d_rmd;
            3'd5: m_readdata = {{(W-1){1'b0}}, d_done};
            default: ;
        endcase
    end

    // Bus / stream monitor.
    int           cyc = 0;
    int           wait_cnt = 0;
    int           wd_viol = 0;
    logic [2:0]   tr_addr[$];
    logic         tr_wr[$];
    logic [W-1:0] tr_data[$];
    int           cap_cyc[$];
    int           hs_cyc[$];
    logic [W-1:0] hs_quo[$];
    logic [W-1:0] hs_rmd[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_chipselect) begin
            tr_addr.push_back(m_address);
            tr_wr.push_back(m_write);
            tr_data.push_back(m_writedata);
        end
        if (busy && !m_chipselect && m_address == 3'd5) wait_cnt = wait_cnt + 1;
        if (!m_write && m_writedata != '0) wd_viol = wd_viol + 1;
        if (in_valid && in_ready) cap_cyc.push_back(cyc);
        if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            hs_quo.push_back(out_quo);
            hs_rmd.push_back(out_rmd);
        end
    end

    task automatic clear_trace();
        tr_addr.delete(); tr_wr.delete(); tr_data.delete();
        cap_cyc.delete(); hs_cyc.delete(); hs_quo.delete(); hs_rmd.delete();
        wait_cnt = 0;
    endtask

    // Present one operand pair and hold it until the block takes it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit taken = 0;
        @(negedge clk);
        in_dvnd = a; in_dvsr = b; in_valid = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            if (in_ready) begin
                @(posedge clk);
                taken = 1;
            end else begin
                @(negedge clk);
            end
        end
        n_vec++;
        if (!taken) begin
            n_err++;
            $display("FAIL send_accept: operands %0d/%0d got taken=%0d, required 1", a, b, taken);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait at negedges for out_valid, bounded by budget cycles.
    task automatic wait_out(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (out_valid) ok = 1;
            else @(negedge clk);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({in_ready, out_valid, out_err, m_chipselect, m_write, busy} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: got {rdy,vld,err,cs,wr,busy}=%b, required 100000",
                     {in_ready, out_valid, out_err, m_chipselect, m_write, busy});
        end
        n_vec++;
        if ({m_address, m_writedata, out_quo, out_rmd} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%0d wd=%h quo=%h rmd=%h, required all zero",
                     m_address, m_writedata, out_quo, out_rmd);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [2:0]   exp_addr[6] = '{3'd6, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic         exp_wr[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] exp_wd[6]   = '{32'd0, 32'd100, 32'd7, 32'd0, 32'd0, 32'd0};
        int bad = 0;
        clear_trace();
        irq_delay = 34;
        send(32'd100, 32'd7);
        wait_out(100, ok);
        n_vec++;
        if (!ok || out_quo !== 32'd14 || out_rmd !== 32'd2 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: got ok=%0d quo=%0d rmd=%0d err=%b, required 1/14/2/0",
                     ok, out_quo, out_rmd, out_err);
        end
        n_vec++;
        if (tr_addr.size() != 6) begin
            n_err++;
            $display("FAIL basic_trace_len: got %0d bus cycles, required 6", tr_addr.size());
        end else begin
            for (int i = 0; i < 6; i++)
                if (tr_addr[i] !== exp_addr[i] || tr_wr[i] !== exp_wr[i] || tr_data[i] !== exp_wd[i])
                    bad++;
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL basic_trace: got %0d bad bus cycles (first addr=%0d wd=%0d), required 0",
                         bad, tr_addr[0], tr_data[1]);
            end
        end
        // irq rises at the 34th edge after the START edge, so the block sees it in the 35th WAIT cycle.
        n_vec++;
        if (wait_cnt != 35) begin
            n_err++;
            $display("FAIL basic_wait_cycles: got %0d, required 35", wait_cnt);
        end
        accept();
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad = 0;
        clear_trace();
        irq_delay = 5;
        send(32'hFFFF_FFFF, 32'h10);
        wait_out(60, ok);
        n_vec++;
        if (!ok || out_quo !== 32'h0FFF_FFFF || out_rmd !== 32'hF || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL bp_result: got ok=%0d quo=%h rmd=%h err=%b, required 1/0fffffff/f/0",
                     ok, out_quo, out_rmd, out_err);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || out_quo !== 32'h0FFF_FFFF || out_rmd !== 32'hF) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold: got %0d unstable cycles, required 0", bad);
        end
        accept();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, required 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int reads = 0;
        clear_trace();
        irq_delay = 0;
        send(32'd50, 32'd5);
        wait_out(400, ok);
        foreach (tr_addr[i]) if (!tr_wr[i]) reads++;
        n_vec++;
        if (!ok || out_quo !== '0 || out_rmd !== '0 || out_err !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_result: got ok=%0d quo=%h rmd=%h err=%b, required 1/0/0/1",
                     ok, out_quo, out_rmd, out_err);
        end
        n_vec++;
        if (wait_cnt != 255) begin
            n_err++;
            $display("FAIL tmo_wait_cycles: got %0d, required 255", wait_cnt);
        end
        n_vec++;
        if (reads != 0 || tr_addr.size() != 4) begin
            n_err++;
            $display("FAIL tmo_bus: got %0d reads and %0d bus cycles, required 0 and 4", reads, tr_addr.size());
        end
        accept();
    endtask

    task automatic test_div_zero();
        bit ok;
        clear_trace();
        irq_delay = 3;
        send(32'd55, 32'd0);
`ifdef DIV_ZERO_BYPASS_EN
        // send returns at the negedge following the capture edge.
        n_vec++;
        if (out_valid !== 1'b1 || out_quo !== 32'hFFFF_FFFF || out_rmd !== 32'd55 || out_err !== 1'b1) begin
            n_err++;
            $display("FAIL dz_bypass: got vld=%b quo=%h rmd=%0d err=%b, required 1/ffffffff/55/1",
                     out_valid, out_quo, out_rmd, out_err);
        end
        n_vec++;
        if (tr_addr.size() != 0) begin
            n_err++;
            $display("FAIL dz_no_bus: got %0d bus cycles, required 0", tr_addr.size());
        end
`else
        wait_out(60, ok);
        n_vec++;
        if (!ok || out_quo !== 32'hFFFF_FFFF || out_rmd !== 32'd55 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL dz_normal: got ok=%0d quo=%h rmd=%0d err=%b, required 1/ffffffff/55/0",
                     ok, out_quo, out_rmd, out_err);
        end
        n_vec++;
        if (tr_addr.size() != 6) begin
            n_err++;
            $display("FAIL dz_bus: got %0d bus cycles, required 6", tr_addr.size());
        end
`endif
        accept();
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_trace();
        irq_delay = 0;
        send(32'd1, 32'd1);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (m_chipselect !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got cs=%b busy=%b rdy=%b vld=%b, required 0/0/1/0",
                     m_chipselect, busy, in_ready, out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_trace();
        irq_delay = 3;
        send(32'd9, 32'd4);
        wait_out(60, ok);
        n_vec++;
        if (!ok || out_quo !== 32'd2 || out_rmd !== 32'd1 || out_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_next_op: got ok=%0d quo=%0d rmd=%0d err=%b, required 1/2/1/0",
                     ok, out_quo, out_rmd, out_err);
        end
        accept();
    endtask

    task automatic test_back_to_back();
        clear_trace();
        irq_delay = 4;
        out_ready = 1'b1;
        @(negedge clk);
        in_dvnd = 32'd10; in_dvsr = 32'd3; in_valid = 1'b1;
        for (int i = 0; i < 200 && cap_cyc.size() < 1; i++) @(negedge clk);
        in_dvnd = 32'd21; in_dvsr = 32'd5;
        for (int i = 0; i < 200 && cap_cyc.size() < 2; i++) @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 200 && hs_cyc.size() < 2; i++) @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
        if (hs_cyc.size() != 2 || cap_cyc.size() != 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results %0d captures, required 2 and 2",
                     hs_cyc.size(), cap_cyc.size());
        end else begin
            n_vec++;
            if (hs_quo[0] !== 32'd3 || hs_rmd[0] !== 32'd1 || hs_quo[1] !== 32'd4 || hs_rmd[1] !== 32'd1) begin
                n_err++;
                $display("FAIL b2b_results: got %0d/%0d then %0d/%0d, required 3/1 then 4/1",
                         hs_quo[0], hs_rmd[0], hs_quo[1], hs_rmd[1]);
            end
            n_vec++;
            if (cap_cyc[1] != hs_cyc[0] + 1) begin
                n_err++;
                $display("FAIL b2b_capture_cycle: got %0d, required %0d", cap_cyc[1], hs_cyc[0] + 1);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_dvnd = '0; in_dvsr = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_basic();
        test_backpressure();
        test_timeout();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        n_vec++;
        if (wd_viol != 0) begin
            n_err++;
            $display("FAIL writedata_idle: got %0d nonzero cycles without write, required 0", wd_viol);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
